stream_demux: RTL
=================

# stream_demux

Registered, parameterised 1-to-N stream demultiplexer with valid/ready handshaking on the input and on every output channel. It is the clocked successor of the combinational 4-way demux. It adds configurable data width and channel count, a one-word output register per channel with backpressure, broadcast mode, per-channel enables, and a saturating drop counter. It sits between a single producer and N independent consumers that may stall individually.

## Interface
- SELW, default 2: select width; channel count NCH = 2**SELW (default 4).
- WIDTH, default 8: data word width in bits.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel for unicast words.
- in_bcast  input  1  1 = word goes to every enabled channel; in_sel is ignored.
- in_valid  input  1  producer holds a word.
- in_ready  output  1  block accepts the word this cycle.
- chan_en  input  NCH  per-channel enable; 0 = words routed there are dropped.
- out_data  output  NCH*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  NCH  channel i register holds a word.
- out_ready  input  NCH  consumer i takes its word this cycle.
- drop_cnt  output  16  number of words dropped, saturating.

## Operation
- **Per-channel load condition:** can_load[i] = !out_valid[i] || out_ready[i].
- **Target set T** (NCH bits):
  - if in_bcast = 1: T = chan_en.
  - otherwise: T = onehot(in_sel) & chan_en.
- **Ready:** in_ready = !rst && (can_load | ~T) == all ones.
  - If T = 0, in_ready = 1 and the word is dropped.
  - in_ready is combinational from in_sel, in_bcast, chan_en, out_valid and out_ready. It never depends on in_valid.
- **Accept:** accept = in_valid && in_ready.
- **Per channel i, every clock edge, in priority order:**
  - rst: out_valid[i] <= 0, out_data[i] <= 0.
  - accept && T[i]: out_data[i] <= in_data, out_valid[i] <= 1. This covers a simultaneous drain and reload, i.e. back-to-back words on the same channel.
  - out_valid[i] && out_ready[i]: out_valid[i] <= 0. out_data[i] holds its last value.
  - Otherwise: hold.
- **Drop counter:**
  - accept && T == 0 increments drop_cnt by 1.
  - It saturates at 16'hFFFF and never wraps.
  - It is cleared only by rst.
- **Broadcast is all-or-nothing.** The word is accepted only when every enabled channel can load. No partial delivery.
- **chan_en changes** affect only words presented from that cycle on. A word already held in a channel register still drains normally even if that channel is disabled.
- **Outputs while valid:** out_valid[i] and out_data[i] remain stable until out_ready[i] is sampled high.
- **Independence:** channels not in T are never disturbed by an accept.

## Timing
- **Reset values:** out_valid = 0, out_data = 0, drop_cnt = 0. in_ready = 0 while rst = 1.
- **Latency:** a word accepted at edge k shows out_valid[i] = 1 and the new out_data[i] immediately after edge k, i.e. one cycle.
- **Throughput:** one word per cycle. Each channel can sustain one word per cycle when its out_ready is held at 1.
- **Drop timing:** a dropped word completes in one cycle; drop_cnt updates at the same edge.
- **Reset mid-operation:** rst high at an edge discards all held words, even if in_valid and in_ready, or out_ready, are also high in that cycle. No transfer is counted.
- **Combinational path:** out_ready → in_ready is combinational. There is no combinational path from in_valid or in_data to any output.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid = 1, in_data = 8'hAA → out_valid = 4'b0000, out_data = 0, drop_cnt = 0, in_ready = 0 throughout.
- **Unicast sweep:** chan_en = 4'hF, out_ready = 4'hF, in_data = 8'h11, 22, 33, 44 on in_sel = 0, 1, 2, 3 in consecutive cycles → each out_valid[i] pulses for exactly one cycle, one cycle after its word, carrying the matching data. in_ready stays 1.
- **Backpressure:** out_ready[2] = 0. Send 8'h5A then 8'h5B to sel = 2 → first word accepted; in_ready = 0 while the second is offered. Raise out_ready[2] → 5A taken, 5B loaded in the same edge, out_valid[2] stays 1.
- **Broadcast:** chan_en = 4'b1011, in_bcast = 1, in_data = 8'hC3, out_ready[3] = 0 with channel 3 full → in_ready = 0 and no channel loads. Release out_ready[3] → channels 0, 1, 3 load C3; channel 2 stays 0.
- **Drop and saturation:** chan_en = 0, in_valid = 1 for 5 cycles → in_ready = 1, no out_valid, drop_cnt = 5. Preload drop_cnt near the top (force, or 65540 cycles) → it stops at 16'hFFFF.
- **Disable with word held:** hold a word on channel 1 (out_ready[1] = 0), then clear chan_en[1] → out_valid[1] stays 1 with unchanged data until out_ready[1] = 1. New sel = 1 words are counted in drop_cnt.

Source files
------------

// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - handshake bundle between producer, stream_demux and its consumers
interface stream_demux_if #(
  parameter int SELW  = 2,
  parameter int WIDTH = 8
);
  localparam int NCH = 2 ** SELW;

  logic [WIDTH-1:0]     in_data;
  logic [SELW-1:0]      in_sel;
  logic                 in_bcast;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demux with broadcast, channel enables and drop counter
module stream_demux #(
  parameter int SELW  = 2,
  parameter int WIDTH = 8,
  localparam int NCH  = 2 ** SELW
) (
  input  logic              clk,
  input  logic              rst,
  stream_demux_if.slave     bus,
  input  logic [NCH-1:0]    chan_en,
  output logic [15:0]       drop_cnt
);
  logic [NCH-1:0]       tgt;
  logic [NCH-1:0]       can_load;
  logic                 accept;
  logic [NCH-1:0]       out_valid_q, out_valid_d;
  logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  always_comb begin
    tgt         = bus.in_bcast ? chan_en : ((NCH'(1) << bus.in_sel) & chan_en);
    can_load    = ~out_valid_q | bus.out_ready;
    // Broadcast is all-or-nothing: every targeted channel must be able to load.
    bus.in_ready = !rst && ((can_load | ~tgt) == {NCH{1'b1}});
    accept      = bus.in_valid && bus.in_ready;

    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    for (int i = 0; i < NCH; i++) begin
      if (accept && tgt[i]) begin
        out_valid_d[i]                = 1'b1;
        out_data_d[i*WIDTH +: WIDTH]  = bus.in_data;
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (accept && (tgt == '0) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign drop_cnt      = drop_cnt_q;
endmodule
